apb_req_scheduler: RTL and testbench
====================================

// Module: apb_req_scheduler
// PURPOSE
//  Shares one APB master (setup/enable FSM, newd/pready handshake) between NREQ local requesters.
//  Round-robin arbitration; one complete APB transfer per grant; per-requester done pulse.
//  Shared read-data return. Timeout watchdog on pready.
//  Sits between requester logic and the APB master; observes the APB bus to detect completion.
// PARAMETERS
//  NREQ   4    number of requesters (2..8)
//  AW     4    APB address width
//  DW     8    APB data width
//  TMO    15   max ENABLE-phase wait cycles for pready before abort (>=1)
// PORTS
//  pclk        in   1        clock; all logic on rising edge
//  presetn     in   1        reset, synchronous, ACTIVE-HIGH (1 = reset)
//  req         in   NREQ     per-requester transfer request, level; held until own done
//  req_addr    in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  req_wdata   in   NREQ*DW  packed write data, requester i at [i*DW +: DW]
//  req_wr      in   NREQ     1=write, 0=read
//  gnt         out  NREQ     one-hot; current owner, high IDLE->XFER exit through DONE
//  done        out  NREQ     one-cycle pulse to owner when its transfer ends
//  err         out  1        valid with done; 1 = aborted by timeout
//  rdata       out  DW       read data of last completed read; held until next read completes
//  m_newd      out  1        to master newd
//  m_addr      out  AW       to master addrin (latched)
//  m_wdata     out  DW       to master datain (latched)
//  m_wr        out  1        to master wr (latched)
//  m_psel      in   1        APB psel (monitored)
//  m_penable   in   1        APB penable (monitored)
//  m_pready    in   1        APB pready (monitored)
//  m_prdata    in   DW       APB prdata (monitored)
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, done=0, err=0, rdata=0, m_newd=0, m_addr/m_wdata/m_wr=0, rr_ptr=0, tmo_cnt=0.
//  Reset mid-transfer: everything above returns to reset values; m_newd=0 drives master to idle;
//   no done is issued for the aborted transfer.
//  FSM IDLE -> XFER -> DONE -> IDLE.
//  IDLE: if |req, pick winner = first requester with req=1 at or after rr_ptr, modulo NREQ.
//   Latch its addr/wdata/wr into m_*; set gnt one-hot; next state XFER.
//   Otherwise stay in IDLE.
//  XFER: m_newd = (state==XFER) & ~cmpl (combinational), where cmpl = m_psel & m_penable & m_pready.
//   The master therefore returns to idle right after a single transfer (no back-to-back repeat).
//   On cmpl: if !m_wr, rdata <= m_prdata; err <= 0; next state DONE.
//   tmo_cnt counts cycles with m_psel & m_penable & !m_pready; reset to 0 on XFER entry.
//   When tmo_cnt==TMO and still !m_pready: m_newd=0 that cycle, err <= 1, rdata unchanged, next state DONE.
//  DONE: done[owner]=1 for exactly this cycle; gnt cleared at end of cycle.
//   rr_ptr <= (owner+1) mod NREQ; next state IDLE.
//  Minimum spacing: req seen -> done = 1(IDLE) + 2(setup, enable with pready=1) + 1(DONE) = 4 cycles.
//   One IDLE cycle always separates grants.
//  req dropped during XFER: transfer still completes and done still pulses (no abort).
//  req still high after own done: treated as a new request. The RR pointer has already moved past it,
//   so another pending requester wins first.
//  Latched m_addr/m_wdata/m_wr ignore req_* changes after the IDLE latch cycle.
//  Simultaneous completion and timeout in the same cycle: completion wins, err=0.
//  All latched outputs hold their values in IDLE (no zeroing).
// STRUCTURE
//  Shared package/include apb_arb_pkg: state encoding (IDLE=0, XFER=1, DONE=2),
//   default AW/DW constants, onehot->index function.
//  Sub-module rr_arbiter #(NREQ): combinational; inputs req, ptr; outputs gnt_onehot, gnt_idx, any.
//   Instantiated once.
//  Top level holds the FSM, latches, timeout counter and rr_ptr.
// TESTING
//  Bench instantiates this block with the existing APB master and a behavioural slave (programmable pready delay).
//  1 Single write: req[0]=1, addr=4'h3, wdata=8'hA5, wr=1, pready=1 -> one setup+enable on bus,
//    pwdata=A5, done[0] 4 cycles after req, err=0.
//  2 Read: req[2]=1, addr=4'h7, slave prdata=8'h3C -> rdata=3C at done[2]; exactly one psel burst.
//  3 Contention: req=4'b1111 held, each drops after own done -> grant order 0,1,2,3.
//    Re-raise all -> order continues 0,1,2,3 from the updated pointer.
//  4 Wait states: pready delayed 5 cycles, TMO=15 -> done with err=0, penable high 6 cycles.
//    pready never asserted -> done at TMO+1 enable cycles, err=1, master back to idle.
//  5 Reset mid-XFER: assert presetn during enable phase -> next cycle gnt=0, m_newd=0,
//    no done pulse, master psel=0 within 1 cycle.
//  6 Hold-over: req[1] held high through its done while req[3]=1 -> next grant goes to 3, then 1.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB request scheduler:
// FSM state encoding, default widths, one-hot decode.
package apb_arb_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // one-hot (up to 8 bits) to binary index
  function automatic logic [2:0] oh2idx(
    input logic [7:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first
// requester at or after ptr, modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  int j;

  // scan from ptr, take the first request found
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    j          = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any           = 1'b1;
        gnt_onehot[j] = 1'b1;
        gnt_idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_req_scheduler.sv
// Shares one APB master between NREQ requesters:
// round-robin grant, one transfer per grant, pready watchdog.
module apb_req_scheduler
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int TMO  = 15
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0] req_wr,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic [DW-1:0]   rdata,
  output logic            m_newd,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic            m_wr,
  input  logic            m_psel,
  input  logic            m_penable,
  input  logic            m_pready,
  input  logic [DW-1:0]   m_prdata
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TMO + 1);

  state_t          state;
  state_t          nstate;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   own_idx;
  logic [NREQ-1:0] win_oh;
  logic            win_any;
  logic [CW-1:0]   tmo_cnt;
  logic            cmpl;
  logic            wait_cyc;
  logic            tmo_hit;

  assign cmpl     = m_psel & m_penable & m_pready;
  assign wait_cyc = m_psel & m_penable & ~m_pready;
  assign tmo_hit  = (state == ST_XFER) & wait_cyc
                  & (tmo_cnt == CW'(TMO));
  assign own_idx  = IW'(oh2idx(8'(gnt)));

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_onehot(win_oh),
    .gnt_idx   (win_idx),
    .any       (win_any)
  );

  // state register
  always_ff @(posedge pclk) begin
    if (presetn) state <= ST_IDLE;
    else         state <= nstate;
  end

  // next state, master request and done pulse
  always_comb begin
    nstate = state;
    m_newd = 1'b0;
    done   = '0;
    unique case (state)
      ST_IDLE: begin
        if (win_any) nstate = ST_XFER;
      end
      ST_XFER: begin
        m_newd = ~cmpl & ~tmo_hit;
        if (cmpl || tmo_hit) nstate = ST_DONE;
      end
      ST_DONE: begin
        done   = gnt;
        nstate = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // grant, request latches, read data, watchdog, pointer
  always_ff @(posedge pclk) begin
    if (presetn) begin
      gnt     <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wr    <= 1'b0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == ST_IDLE && win_any) begin
        gnt     <= win_oh;
        m_addr  <= req_addr[win_idx*AW +: AW];
        m_wdata <= req_wdata[win_idx*DW +: DW];
        m_wr    <= req_wr[win_idx];
        tmo_cnt <= '0;
      end
      if (state == ST_XFER) begin
        if (cmpl) begin
          if (!m_wr) rdata <= m_prdata;
          err <= 1'b0;
        end else if (tmo_hit) begin
          err <= 1'b1;
        end else if (wait_cyc) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
      if (state == ST_DONE) begin
        gnt    <= '0;
        rr_ptr <= (own_idx == IW'(NREQ - 1))
                ? '0 : own_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Bench: scheduler + behavioural APB master/slave,
// scoreboard of expected done events.
module tb_apb_req_scheduler;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int TMO  = 15;

  logic pclk = 1'b0;
  logic presetn = 1'b1;
  always #5 pclk = ~pclk;

  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    req_wr = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [DW-1:0]      rdata;
  logic               m_newd;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic               m_wr;
  logic               m_psel;
  logic               m_penable;
  logic               m_pready;
  logic [DW-1:0]      m_prdata;

  apb_req_scheduler #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TMO(TMO)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .req      (req),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wr   (req_wr),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .m_newd   (m_newd),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wr     (m_wr),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_pready (m_pready),
    .m_prdata (m_prdata)
  );

  // behavioural APB master: setup/enable on newd
  typedef enum logic [1:0] {
    M_IDLE, M_SETUP, M_EN
  } mst_t;
  mst_t mst = M_IDLE;

  always @(posedge pclk) begin
    case (mst)
      M_IDLE:  mst <= m_newd ? M_SETUP : M_IDLE;
      M_SETUP: mst <= m_newd ? M_EN : M_IDLE;
      M_EN: begin
        if (m_pready) mst <= m_newd ? M_SETUP : M_IDLE;
        else          mst <= m_newd ? M_EN : M_IDLE;
      end
      default: mst <= M_IDLE;
    endcase
  end

  assign m_psel    = (mst != M_IDLE);
  assign m_penable = (mst == M_EN);

  // behavioural slave with programmable wait states
  int delay = 0;
  int wcnt = 0;
  logic [7:0] mem [16] = '{7: 8'h3C, default: 8'h00};

  assign m_pready = m_penable && (wcnt >= delay);
  assign m_prdata = mem[m_addr];

  always @(posedge pclk) begin
    if (m_penable && !m_pready) wcnt <= wcnt + 1;
    else                        wcnt <= 0;
    if (m_psel && m_penable && m_pready && m_wr)
      mem[m_addr] <= m_wdata;
  end

  // bus tracker: bursts, enable cycles, completed beat
  int bursts = 0;
  int en_run = 0;
  logic psel_q = 1'b0;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_wdata = '0;
  logic bus_wr = 1'b0;

  always @(posedge pclk) begin
    psel_q <= m_psel;
    if (m_psel && !psel_q) begin
      bursts <= bursts + 1;
      en_run <= 0;
    end else if (m_psel && m_penable) begin
      en_run <= en_run + 1;
    end
    if (m_psel && m_penable && m_pready) begin
      bus_addr  <= m_addr;
      bus_wdata <= m_wdata;
      bus_wr    <= m_wr;
    end
  end

  // scoreboard
  typedef struct {
    int         idx;
    bit         err;
    bit         wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    int         en;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push(input int idx, input bit e,
                      input bit wr, input logic [3:0] a,
                      input logic [7:0] d,
                      input logic [7:0] rd, input int en);
    exp_t x;
    x.idx = idx; x.err = e; x.wr = wr;
    x.addr = a; x.wdata = d; x.rd = rd; x.en = en;
    sb.push_back(x);
  endtask

  // monitor: compare each done against the queue head
  always @(negedge pclk) begin
    exp_t e;
    if (done != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got %b expected none",
                 done);
      end else begin
        e = sb.pop_front();
        chk("done_owner", 32'(done), 32'(1 << e.idx));
        chk("gnt_at_done", 32'(gnt), 32'(1 << e.idx));
        chk("err", 32'(err), 32'(e.err));
        chk("rdata", 32'(rdata), 32'(e.rd));
        chk("enable_cycles", en_run, e.en);
        if (!e.err) begin
          chk("bus_addr", 32'(bus_addr), 32'(e.addr));
          chk("bus_wr", 32'(bus_wr), 32'(e.wr));
          if (e.wr)
            chk("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
        end
      end
    end
  end

  task automatic set_req(input int i, input bit wr,
                         input logic [3:0] a,
                         input logic [7:0] d);
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // drive until all non-held requests served
  task automatic run(input logic [3:0] hold,
                     input int budget,
                     input bit scramble,
                     output int lat);
    int n;
    n = 0;
    lat = -1;
    while ((req & ~hold) != '0 && n < budget) begin
      @(negedge pclk);
      n++;
      if (scramble && n == 1) begin
        req_addr  = '1;
        req_wdata = '1;
      end
      if (done != '0) begin
        if (lat < 0) lat = n;
        req = req & ~(done & ~hold);
      end
    end
    checks++;
    if ((req & ~hold) != '0) begin
      errors++;
      $display("FAIL run_budget: got req=%b expected 0",
               req & ~hold);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int b0;
    int n;

    presetn = 1'b1;
    repeat (3) @(negedge pclk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_newd", 32'(m_newd), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_wdata", 32'(m_wdata), 0);
    chk("rst_wr", 32'(m_wr), 0);
    presetn = 1'b0;
    repeat (2) @(negedge pclk);

    // single write, req_* scrambled after latch
    set_req(0, 1'b1, 4'h3, 8'hA5);
    push(0, 1'b0, 1'b1, 4'h3, 8'hA5, 8'h00, 1);
    b0 = bursts;
    req = 4'b0001;
    run(4'b0000, 20, 1'b1, lat);
    chk("t1_latency", lat, 4);
    chk("t1_bursts", bursts - b0, 1);
    repeat (2) @(negedge pclk);

    // single read
    set_req(2, 1'b0, 4'h7, 8'h00);
    push(2, 1'b0, 1'b0, 4'h7, 8'h00, 8'h3C, 1);
    b0 = bursts;
    req = 4'b0100;
    run(4'b0000, 20, 1'b0, lat);
    chk("t2_latency", lat, 4);
    chk("t2_bursts", bursts - b0, 1);
    repeat (3) @(negedge pclk);
    chk("t2_rdata_hold", 32'(rdata), 32'h3C);

    // reset to bring rr_ptr back to 0
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    chk("rst2_rdata", 32'(rdata), 0);

    // contention: four writes then four reads
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1, 4'(8 + i), 8'(8'h10 + i));
      push(i, 1'b0, 1'b1, 4'(8 + i),
           8'(8'h10 + i), 8'h00, 1);
    end
    req = 4'b1111;
    run(4'b0000, 80, 1'b0, lat);
    repeat (2) @(negedge pclk);
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b0, 4'(8 + i), 8'h00);
      push(i, 1'b0, 1'b0, 4'(8 + i),
           8'h00, 8'(8'h10 + i), 1);
    end
    req = 4'b1111;
    run(4'b0000, 80, 1'b0, lat);
    repeat (2) @(negedge pclk);

    // five wait states
    delay = 5;
    set_req(1, 1'b1, 4'h4, 8'h5A);
    push(1, 1'b0, 1'b1, 4'h4, 8'h5A, 8'h13, 6);
    req = 4'b0010;
    run(4'b0000, 40, 1'b0, lat);
    chk("t4a_latency", lat, 9);
    repeat (2) @(negedge pclk);

    // pready never comes: watchdog abort
    delay = 1000;
    set_req(2, 1'b0, 4'h8, 8'h00);
    push(2, 1'b1, 1'b0, 4'h8, 8'h00, 8'h13, TMO + 1);
    req = 4'b0100;
    run(4'b0000, 60, 1'b0, lat);
    chk("t4b_latency", lat, 4 + TMO);
    chk("t4b_psel_idle", 32'(m_psel), 0);
    delay = 0;
    repeat (2) @(negedge pclk);

    // reset during enable phase
    delay = 3;
    set_req(3, 1'b1, 4'hD, 8'h99);
    req = 4'b1000;
    n = 0;
    while (!m_penable && n < 20) begin
      @(negedge pclk);
      n++;
    end
    chk("t5_enable_reached", 32'(m_penable), 1);
    presetn = 1'b1;
    req = 4'b0000;
    @(negedge pclk);
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_newd", 32'(m_newd), 0);
    chk("t5_done", 32'(done), 0);
    presetn = 1'b0;
    @(negedge pclk);
    chk("t5_psel", 32'(m_psel), 0);
    repeat (6) @(negedge pclk);
    delay = 0;

    // hold-over: req1 kept through its done
    set_req(1, 1'b0, 4'hA, 8'h00);
    set_req(3, 1'b1, 4'hC, 8'h77);
    push(1, 1'b0, 1'b0, 4'hA, 8'h00, 8'h12, 1);
    push(3, 1'b0, 1'b1, 4'hC, 8'h77, 8'h12, 1);
    push(1, 1'b0, 1'b0, 4'hA, 8'h00, 8'h12, 1);
    req = 4'b1010;
    run(4'b0010, 60, 1'b0, lat);
    run(4'b0000, 60, 1'b0, lat);

    repeat (4) @(negedge pclk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
